// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS-32 core (add/sub/and/or/slt, lw, sw, beq, addi, j)
// with a single shared instruction/data memory port using a req/ready handshake.
//
// Ports:
//   i_clk, i_rst       rising-edge clock, synchronous active-high reset
//   o_mem_req/o_mem_we memory request / write enable (held stable until i_mem_ready)
//   o_mem_addr         byte address, word aligned
//   o_mem_wdata        store data
//   i_mem_ready        access completes when o_mem_req && i_mem_ready
//   i_mem_rdata        read data, valid in the completing cycle
//   o_retire           one-cycle pulse in the final cycle of each instruction
//   o_pc_out           architectural PC
//   o_halted           core stopped on an unsupported instruction
//
// Build option: MIPS_MC_TRAP_EN -- when defined, an unsupported opcode/funct halts
// the core until reset; when undefined it retires as a NOP and o_halted stays 0.

module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_retire,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic              o_halted
);

  localparam int unsigned RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADR, S_MEMRD, S_MEMWR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_alu;
  logic [31:0]       r_mdr;
  logic [31:0]       r_rf [NUM_REGS];
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_retire;
  logic              r_halted;

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [RIDX_W-1:0] w_rs;
  logic [RIDX_W-1:0] w_rt;
  logic [RIDX_W-1:0] w_rd;
  logic [RIDX_W-1:0] w_dst;
  logic [31:0]       w_rf_rs;
  logic [31:0]       w_rf_rt;
  logic [31:0]       w_sext;
  logic [31:0]       w_pc32;
  logic [31:0]       w_alu_r;
  logic [31:0]       w_ea_a;
  logic [31:0]       w_ea_rf;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_j_tgt;
  logic              w_unused;

  // Supported-instruction check, shared by fetch (NOP retire) and decode dispatch
  function automatic logic is_supported(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    case (ins[31:26])
      OP_RTYPE: ok = (ins[5:0] == FN_ADD) || (ins[5:0] == FN_SUB) || (ins[5:0] == FN_AND) ||
                     (ins[5:0] == FN_OR)  || (ins[5:0] == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Instruction fields; register indices alias modulo NUM_REGS by truncation
  assign w_op    = r_ir[31:26];
  assign w_funct = r_ir[5:0];
  assign w_rs    = r_ir[21 +: RIDX_W];
  assign w_rt    = r_ir[16 +: RIDX_W];
  assign w_rd    = r_ir[11 +: RIDX_W];
  assign w_dst   = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_rf_rs = r_rf[w_rs];
  assign w_rf_rt = r_rf[w_rt];
  assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_pc32  = 32'(r_pc);
  assign w_ea_a  = r_a + w_sext;
  assign w_ea_rf = w_rf_rs + w_sext;
  // r_pc already points past the branch, so this is PC+4+offset
  assign w_br_tgt = ADDR_W'(w_pc32 + (w_sext << 2));
  assign w_j_tgt  = ADDR_W'({w_pc32[31:28], r_ir[25:0], 2'b00});
  assign w_unused = ^{r_ir[25:11], r_mdr[0]} & 1'b0;

  // R-type ALU
  always_comb begin
    w_alu_r = r_a + r_b;
    case (w_funct)
      FN_SUB:  w_alu_r = r_a - r_b;
      FN_AND:  w_alu_r = r_a & r_b;
      FN_OR:   w_alu_r = r_a | r_b;
      FN_SLT:  w_alu_r = {31'd0, $signed(r_a) < $signed(r_b)};
      default: w_alu_r = r_a + r_b;
    endcase
  end

  // Control FSM, datapath registers and register file
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FETCH;
      r_pc        <= ADDR_W'(RESET_PC);
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu       <= '0;
      r_mdr       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_retire    <= 1'b0;
      r_halted    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (!r_mem_req) begin
            // first fetch after reset: raise the request
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_ir      <= i_mem_rdata;
            r_pc      <= r_pc + ADDR_W'(4);
            r_state   <= S_DECODE;
`ifndef MIPS_MC_TRAP_EN
            // an unsupported instruction retires in DECODE
            r_retire  <= !is_supported(i_mem_rdata);
`endif
          end
        end
        S_DECODE: begin
          r_a <= w_rf_rs;
          r_b <= w_rf_rt;
          if (!is_supported(r_ir)) begin
`ifdef MIPS_MC_TRAP_EN
            r_state  <= S_HALT;
            r_halted <= 1'b1;
`else
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
`endif
          end else begin
            case (w_op)
              OP_RTYPE: r_state <= S_EXEC_R;
              OP_ADDI:  r_state <= S_EXEC_I;
              OP_LW:    r_state <= S_MEMADR;
              OP_SW: begin
                // store is issued straight from decode so it can retire in its completing cycle + 1
                r_state     <= S_MEMADR;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= ADDR_W'({w_ea_rf[31:2], 2'b00});
                r_mem_wdata <= w_rf_rt;
              end
              OP_BEQ: begin
                r_state  <= S_BRANCH;
                r_retire <= 1'b1;
              end
              default: begin
                r_state  <= S_JUMP;
                r_retire <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC_R: begin
          r_alu    <= w_alu_r;
          r_state  <= S_WB_ALU;
          r_retire <= 1'b1;
        end
        S_EXEC_I: begin
          r_alu    <= w_ea_a;
          r_state  <= S_WB_ALU;
          r_retire <= 1'b1;
        end
        S_MEMADR: begin
          if (w_op == OP_SW) begin
            // store access in flight
            if (i_mem_ready) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_state   <= S_MEMWR;
              r_retire  <= 1'b1;
            end
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= ADDR_W'({w_ea_a[31:2], 2'b00});
            r_state    <= S_MEMRD;
          end
        end
        S_MEMRD: begin
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_mdr     <= i_mem_rdata;
            r_state   <= S_WB_MEM;
            r_retire  <= 1'b1;
          end
        end
        S_WB_ALU, S_WB_MEM: begin
          if (w_dst != '0) r_rf[w_dst] <= (r_state == S_WB_MEM) ? r_mdr : r_alu;
          r_state    <= S_FETCH;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
        end
        S_MEMWR: begin
          r_state    <= S_FETCH;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
        end
        S_BRANCH: begin
          r_state   <= S_FETCH;
          r_mem_req <= 1'b1;
          r_mem_we  <= 1'b0;
          if (r_a == r_b) begin
            r_pc       <= w_br_tgt;
            r_mem_addr <= w_br_tgt;
          end else begin
            r_mem_addr <= r_pc;
          end
        end
        S_JUMP: begin
          r_state    <= S_FETCH;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_pc       <= w_j_tgt;
          r_mem_addr <= w_j_tgt;
        end
        default: begin
          // S_HALT: parked until reset
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_retire    = r_retire | w_unused;
  assign o_pc_out    = r_pc;
  assign o_halted    = r_halted;

endmodule
